syn_i2c_master: RTL and testbench

I2C write-only master that serialises 1 to 3 bytes onto the board I2C bus. It drives `syn_i2c_intf` through its `dut` modport.
- Sits between the codec/peripheral configuration controller (upstream, issues register writes) and the I2C pad interface (downstream).
- Generates START, the data bits, ACK sampling and STOP; aborts with a NACK flag when the slave does not acknowledge.

---
 rtl/syn_i2c_pkg.sv | 16 +
 rtl/syn_i2c_intf.sv | 23 ++
 rtl/syn_i2c_qtr_tick.sv | 27 ++
 rtl/syn_i2c_master.sv | 196 +++++++++++++++++++
 tb/tb_syn_i2c_master.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/syn_i2c_pkg.sv
// Shared types and constants for the write-only I2C master and its helpers.
package syn_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP,
        DONE
    } i2c_state_t;

    localparam int PHASE_W       = 2;
    localparam int I2C_MAX_BYTES = 3;

endpackage

// File: rtl/syn_i2c_intf.sv
// Board I2C pad bundle; the master drives SCL/SDA and reads back the wired SDA level.
interface syn_i2c_intf;

    logic scl;
    logic sda_o;
    logic release_sda;
    logic sda_i;

    modport dut (
        output scl,
        output sda_o,
        output release_sda,
        input  sda_i
    );

    modport bus (
        input  scl,
        input  sda_o,
        input  release_sda,
        output sda_i
    );

endinterface

// File: rtl/syn_i2c_qtr_tick.sv
// SCL quarter-period strobe: counts 0..CLK_DIV-1 and pulses tick on the last count.
module syn_i2c_qtr_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk_ir,
    input  logic rst_il,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/syn_i2c_master.sv
// Write-only I2C master: START, 1..3 bytes MSB first with ACK checks, STOP.
// Pad outputs are decoded from the next state so they change on the same edge as the FSM.
module syn_i2c_master
    import syn_i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic        clk_ir,
    input  logic        rst_il,
    input  logic        start_i,
    input  logic [1:0]  nbytes_i,
    input  logic [23:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        nack_o,
    syn_i2c_intf.dut    i2c_intf
);

    i2c_state_t         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         bytes_left_q, bytes_left_d;
    logic [23:0]        shift_q, shift_d;
    logic               nack_q, nack_d;
    logic               scl_q, scl_d;
    logic               sda_q, sda_d;
    logic               rel_q, rel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               tick;

    assign accept = (state_q == IDLE) && start_i && (nbytes_i != 2'd0);

    syn_i2c_qtr_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtr_tick (
        .clk_ir (clk_ir),
        .rst_il (rst_il),
        .clr    (accept),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        bytes_left_d = bytes_left_q;
        shift_d      = shift_q;
        nack_d       = nack_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = START;
                    phase_d      = '0;
                    shift_d      = data_i;
                    bytes_left_d = nbytes_i;
                    nack_d       = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (phase_q == PHASE_W'(1)) begin
                        state_d = DATA;
                        phase_d = '0;
                        bit_d   = 3'd7;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PHASE_W'(3)) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        if (bit_q == 3'd0) begin
                            state_d = ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end
            ACK: begin
                if (tick) begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PHASE_W'(2)) begin
                        nack_d = i2c_intf.sda_i;
                    end
                    if (phase_q == PHASE_W'(3)) begin
                        if (nack_q || (bytes_left_q == 2'd1)) begin
                            state_d = STOP;
                        end else begin
                            state_d      = DATA;
                            bit_d        = 3'd7;
                            bytes_left_d = bytes_left_q - 2'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (phase_q == PHASE_W'(2)) begin
                        state_d = DONE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus levels for the state being entered, so they register alongside it.
    always_comb begin
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        rel_d  = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b0;

        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
            end
            START: begin
                rel_d = 1'b0;
                sda_d = (phase_d == '0);
            end
            DATA: begin
                scl_d = phase_d[1];
                rel_d = 1'b0;
                sda_d = shift_d[23];
            end
            ACK: begin
                scl_d = phase_d[1];
            end
            STOP: begin
                scl_d = (phase_d != '0);
                sda_d = (phase_d == PHASE_W'(2));
                rel_d = (phase_d == PHASE_W'(2));
            end
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            bit_q        <= '0;
            bytes_left_q <= '0;
            shift_q      <= '0;
            nack_q       <= 1'b0;
            scl_q        <= 1'b1;
            sda_q        <= 1'b1;
            rel_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            bytes_left_q <= bytes_left_d;
            shift_q      <= shift_d;
            nack_q       <= nack_d;
            scl_q        <= scl_d;
            sda_q        <= sda_d;
            rel_q        <= rel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign i2c_intf.scl         = scl_q;
    assign i2c_intf.sda_o       = sda_q;
    assign i2c_intf.release_sda = rel_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign nack_o               = nack_q;

endmodule

// File: tb/tb_syn_i2c_master.sv
// Scoreboard bench for syn_i2c_master: a slave/bus model decodes the wire and checks timing,
// while requests push expected outcomes that are popped on each done_o pulse.
module tb_syn_i2c_master;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic        nack;
        int          nsent;
        logic [23:0] bytes;
        int          lat;
        int          issue;
    } exp_t;

    logic        clk;
    logic        rst_il;
    logic        start_i;
    logic [1:0]  nbytes_i;
    logic [23:0] data_i;
    logic        busy_o;
    logic        done_o;
    logic        nack_o;

    syn_i2c_intf i2c_if ();

    syn_i2c_master #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk_ir   (clk),
        .rst_il   (rst_il),
        .start_i  (start_i),
        .nbytes_i (nbytes_i),
        .data_i   (data_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .nack_o   (nack_o),
        .i2c_intf (i2c_if)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    logic [2:0]  ack_mask   = 3'b000;
    logic        slave_pull = 1'b0;
    logic        bus_sda;

    // Open-drain wire: released SDA floats high unless the slave pulls it down.
    assign bus_sda       = (i2c_if.release_sda ? 1'b1 : i2c_if.sda_o) & ~slave_pull;
    assign i2c_if.sda_i  = bus_sda;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [23:0] byteMask(input int n);
        logic [23:0] ones;
        ones = 24'hFFFFFF;
        return ~(ones >> (8 * n));
    endfunction

    task automatic applyStimulus(input logic [1:0] nb, input logic [23:0] data, input logic [2:0] mask,
                                 input logic exp_nack, input int exp_nsent, input int exp_lat);
        exp_t e;
        @(negedge clk);
        nbytes_i = nb;
        data_i   = data;
        ack_mask = mask;
        start_i  = 1'b1;
        if (nb != 2'd0) begin
            e.nack  = exp_nack;
            e.nsent = exp_nsent;
            e.bytes = data & byteMask(exp_nsent);
            e.lat   = exp_lat;
            e.issue = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
        checkOutput("busy_after_req", {31'd0, busy_o}, {31'd0, (nb != 2'd0)});
        if (nb != 2'd0) begin
            checkOutput("nack_cleared", {31'd0, nack_o}, 32'd0);
        end
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no done_o after %0d cycles, required %0d pending", n, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Bus model state
    logic        prev_scl   = 1'b1;
    logic        prev_sda   = 1'b1;
    logic        scl_now;
    logic        sda_now;
    logic        in_frame   = 1'b0;
    logic        rise_valid = 1'b0;
    logic        fall_valid = 1'b0;
    int          rise_cyc   = 0;
    int          fall_cyc   = 0;
    int          low_len;
    int          mon_cyc    = 0;
    int          bit_cnt    = 0;
    int          byte_idx   = 0;
    int          short_lows = 0;
    int          stops      = 0;
    logic [7:0]  shreg      = 8'h00;
    logic [23:0] got        = 24'h0;
    exp_t        e_mon;

    // Slave/bus decoder, protocol checks and scoreboard pop, all sampled on the falling clock.
    always @(negedge clk) begin
        mon_cyc++;
        scl_now = i2c_if.scl;
        sda_now = bus_sda;
        if (!rst_il) begin
            in_frame   = 1'b0;
            rise_valid = 1'b0;
            fall_valid = 1'b0;
            bit_cnt    = 0;
            byte_idx   = 0;
            slave_pull = 1'b0;
        end else begin
            if (prev_scl && scl_now && (sda_now != prev_sda)) begin
                if (!sda_now) begin
                    checkOutput("start_in_frame", {31'd0, in_frame}, 32'd0);
                    in_frame   = 1'b1;
                    bit_cnt    = 0;
                    byte_idx   = 0;
                    shreg      = 8'h00;
                    got        = 24'h0;
                    short_lows = 0;
                    stops      = 0;
                    rise_valid = 1'b0;
                    fall_valid = 1'b0;
                end else begin
                    checkOutput("stop_bit_align", bit_cnt, 0);
                    in_frame = 1'b0;
                    stops++;
                end
            end
            if (!prev_scl && scl_now) begin
                if (fall_valid) begin
                    low_len = mon_cyc - fall_cyc;
                    if (low_len == CLK_DIV) begin
                        short_lows++;
                    end else begin
                        checkOutput("scl_low_len", low_len, 2 * CLK_DIV);
                        if (bit_cnt == 8) begin
                            bit_cnt = 0;
                            byte_idx++;
                        end else begin
                            shreg = {shreg[6:0], sda_now};
                            bit_cnt++;
                            if (bit_cnt == 8 && byte_idx < 3) got[(23 - 8 * byte_idx) -: 8] = shreg;
                        end
                    end
                end
                rise_valid = 1'b1;
                rise_cyc   = mon_cyc;
            end
            if (prev_scl && !scl_now) begin
                if (rise_valid) checkOutput("scl_high_len", mon_cyc - rise_cyc, 2 * CLK_DIV);
                fall_valid = 1'b1;
                fall_cyc   = mon_cyc;
                slave_pull = (bit_cnt == 8) && (byte_idx < 3) && ack_mask[byte_idx];
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", {31'd0, done_o}, 32'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    checkOutput("nack", {31'd0, nack_o}, {31'd0, e_mon.nack});
                    checkOutput("done_latency", cyc - e_mon.issue, e_mon.lat);
                    checkOutput("bytes_sent", byte_idx, e_mon.nsent);
                    checkOutput("bytes_decoded", {8'd0, got}, {8'd0, e_mon.bytes});
                    checkOutput("stop_low_count", short_lows, 1);
                    checkOutput("stop_seen", stops, 1);
                    checkOutput("busy_at_done", {31'd0, busy_o}, 32'd0);
                end
            end
        end
        prev_scl = scl_now;
        prev_sda = sda_now;
    end

    initial begin
        rst_il   = 1'b0;
        start_i  = 1'b0;
        nbytes_i = 2'd0;
        data_i   = 24'h0;
        repeat (2) @(negedge clk);
        checkOutput("rst_scl",  {31'd0, i2c_if.scl},         32'd1);
        checkOutput("rst_sda",  {31'd0, i2c_if.sda_o},       32'd1);
        checkOutput("rst_rel",  {31'd0, i2c_if.release_sda}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy_o},             32'd0);
        checkOutput("rst_done", {31'd0, done_o},             32'd0);
        checkOutput("rst_nack", {31'd0, nack_o},             32'd0);
        rst_il = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] 3-byte write, all ACKed");
        applyStimulus(2'd3, 24'h341E00, 3'b111, 1'b0, 3, 453);
        waitDone(2000);

        $display("[TB] 3-byte write, NACK on address byte");
        applyStimulus(2'd3, 24'h341E00, 3'b000, 1'b1, 1, 165);
        waitDone(2000);

        $display("[TB] 2-byte write with ignored start at cycle 50");
        applyStimulus(2'd2, 24'hA05AFF, 3'b011, 1'b0, 2, 309);
        repeat (48) @(negedge clk);
        nbytes_i = 2'd3;
        data_i   = 24'hFFFFFF;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        waitDone(2000);
        repeat (20) @(negedge clk);

        $display("[TB] 2-byte write, NACK on second byte");
        applyStimulus(2'd2, 24'h12C37E, 3'b001, 1'b1, 2, 309);
        waitDone(2000);

        $display("[TB] nbytes=0 request");
        applyStimulus(2'd0, 24'h555555, 3'b111, 1'b0, 0, 0);
        repeat (10) @(negedge clk);
        checkOutput("zero_busy",    {31'd0, busy_o},     32'd0);
        checkOutput("zero_scl",     {31'd0, i2c_if.scl}, 32'd1);
        checkOutput("zero_sda_bus", {31'd0, bus_sda},    32'd1);

        $display("[TB] reset mid-DATA then 1-byte write");
        applyStimulus(2'd3, 24'h341E00, 3'b111, 1'b0, 3, 453);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2 rst_il = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("midrst_scl",  {31'd0, i2c_if.scl},         32'd1);
        checkOutput("midrst_rel",  {31'd0, i2c_if.release_sda}, 32'd1);
        checkOutput("midrst_busy", {31'd0, busy_o},             32'd0);
        repeat (3) @(negedge clk);
        rst_il = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(2'd1, 24'hA5BEEF, 3'b001, 1'b0, 1, 165);
        waitDone(2000);

        repeat (30) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
